// File: rtl/audio_pkg.sv
// Shared types for the Pi SPI sample link: sample format, SPI frame layout and TX FSM states.
package audio_pkg;

  localparam int FRAME_BITS = 16;
  localparam int SEQ_BITS   = 3;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef logic [10:0] sm_voltage_t;

  localparam int ENTRY_BITS = SEQ_BITS + $bits(sm_voltage_t);

  typedef struct packed {
    logic                valid;
    logic                ovf;
    logic [SEQ_BITS-1:0] seq;
    sm_voltage_t         sample;
  } spi_frame_t;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} tx_state_t;

  // An invalid frame is all zeros so the Pi can tell "no sample" from any real one.
  function automatic spi_frame_t make_frame(input logic valid, input logic ovf,
                                            input logic [ENTRY_BITS-1:0] entry);
    spi_frame_t f;
    f = '0;
    if (valid) begin
      f.valid  = 1'b1;
      f.ovf    = ovf;
      f.seq    = entry[ENTRY_BITS-1 -: SEQ_BITS];
      f.sample = entry[$bits(sm_voltage_t)-1:0];
    end
    return f;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for captured samples; a push into a full FIFO succeeds only when a pop
// happens in the same cycle (the read always sees pre-push contents).
module sample_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !do_push) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/pi_spi_sample_tx.sv
// SPI-slave (mode 0) transmitter streaming captured audio samples to the Raspberry Pi.
// Optional SPI_TX_RAMP_EN adds ramp_sel, substituting an internal ramp for link bring-up.
module pi_spi_sample_tx
  import audio_pkg::*;
#(
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [9:0] CAPTURE_COUNT = 10'h5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    counter,
  input  sm_voltage_t                   send_voltage,
  input  logic                          sck,
  input  logic                          cs_n,
`ifdef SPI_TX_RAMP_EN
  input  logic                          ramp_sel,
`endif
  output logic                          miso,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  tx_state_t              state, state_nxt;
  logic                   sck_s1, sck_s2, sck_d;
  logic                   cs_s1, cs_s2, cs_d;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic                   fifo_pop, frame_load, shift_en, cnt_dec, abort;
  logic                   fifo_full, fifo_empty, popped, capture, drop;
  logic [ENTRY_BITS-1:0]  fifo_rd;
  logic [SEQ_BITS-1:0]    seq;
  sm_voltage_t            cap_sample;
  spi_frame_t             frame_next;
  logic [FRAME_BITS-1:0]  shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_d <= 1'b0;
      cs_s1  <= 1'b1; cs_s2  <= 1'b1; cs_d  <= 1'b1;
    end else begin
      sck_s1 <= sck;  sck_s2 <= sck_s1; sck_d <= sck_s2;
      cs_s1  <= cs_n; cs_s2  <= cs_s1;  cs_d  <= cs_s2;
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign cs_rise  = cs_s2 & ~cs_d;
  assign cs_fall  = ~cs_s2 & cs_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    frame_load = 1'b0;
    shift_en   = 1'b0;
    cnt_dec    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_nxt = LOAD;
      LOAD: begin
        fifo_pop   = 1'b1;
        frame_load = 1'b1;
        if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          shift_en = sck_fall;
          if (sck_rise) begin
            cnt_dec = 1'b1;
            if (bit_cnt == '0) state_nxt = DONE;
          end
        end
      end
      DONE: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SPI_TX_RAMP_EN
  logic [9:0] ramp_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    ramp_cnt <= '0;
    else if (capture && ramp_sel) ramp_cnt <= ramp_cnt + 10'd1;
  end

  assign cap_sample = ramp_sel ? {1'b0, ramp_cnt} : send_voltage;
`else
  assign cap_sample = send_voltage;
`endif

  assign capture = (counter == CAPTURE_COUNT);
  assign popped  = fifo_pop & ~fifo_empty;
  // full implies non-empty, so a same-cycle pop always makes room
  assign drop    = capture & fifo_full & ~fifo_pop;

  sample_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (capture),
    .pop     (fifo_pop),
    .wr_data ({seq, cap_sample}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign frame_next = make_frame(popped, overflow, fifo_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) seq <= seq + SEQ_BITS'(1);
      if (drop || abort)  overflow <= 1'b1;
      else if (popped)    overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      miso    <= 1'b0;
    end else begin
      if (frame_load)    shreg <= frame_next;
      else if (shift_en) shreg <= {shreg[FRAME_BITS-2:0], 1'b0};

      if (frame_load)   bit_cnt <= BIT_CNT_W'(FRAME_BITS - 1);
      else if (cnt_dec) bit_cnt <= bit_cnt - BIT_CNT_W'(1);

      if (state_nxt == IDLE) miso <= 1'b0;
      else if (frame_load)   miso <= frame_next[FRAME_BITS-1];
      else if (shift_en)     miso <= shreg[FRAME_BITS-2];
    end
  end

endmodule

// File: tb/tb_pi_spi_sample_tx.sv
// Scoreboard bench for pi_spi_sample_tx: an SPI master drives frames, a reference model
// predicts each frame into a queue, and a separate monitor pops and compares received words.
module tb_pi_spi_sample_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  counter;
  logic [10:0] send_voltage;
  logic        sck;
  logic        cs_n;
  logic        miso;
  logic [3:0]  fifo_level;
  logic        overflow;
`ifdef SPI_TX_RAMP_EN
  logic        ramp_sel;
`endif

  pi_spi_sample_tx dut (
    .clk          (clk),
    .reset        (reset),
    .counter      (counter),
    .send_voltage (send_voltage),
    .sck          (sck),
    .cs_n         (cs_n),
`ifdef SPI_TX_RAMP_EN
    .ramp_sel     (ramp_sel),
`endif
    .miso         (miso),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [13:0] mq[$];
  logic [2:0]  seq_m;
  bit          ovf_m;
  logic [9:0]  ramp_m;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    seq_m  = '0;
    ovf_m  = 1'b0;
    ramp_m = '0;
  endtask

  task automatic model_capture(input logic [10:0] val);
    logic [10:0] smp;
    smp = val;
`ifdef SPI_TX_RAMP_EN
    if (ramp_sel) begin
      smp = {1'b0, ramp_m};
      ramp_m = ramp_m + 10'd1;
    end
`endif
    if (mq.size() < 8) mq.push_back({seq_m, smp});
    else               ovf_m = 1'b1;
    seq_m = seq_m + 3'd1;
  endtask

  task automatic model_frame_start(output logic [15:0] f);
    logic [13:0] e;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      f = {1'b1, ovf_m, e};
      ovf_m = 1'b0;
    end else begin
      f = 16'h0000;
    end
  endtask

  function automatic logic [9:0] idle_count();
    logic [9:0] v;
    v = 10'($urandom_range(0, 1023));
    if (v == 10'h5) v = 10'h6;
    return v;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic capture(input logic [10:0] val);
    @(negedge clk);
    counter      = 10'h5;
    send_voltage = val;
    model_capture(val);
    @(negedge clk);
    counter      = idle_count();
    send_voltage = 11'($urandom);
  endtask

  task automatic sck_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  // n_sck < 16 aborts the frame; cap_at_load lands a capture in the LOAD cycle
  task automatic spi_frame(input int n_sck, input bit cap_at_load, input logic [10:0] cap_val);
    logic [15:0] f;
    model_frame_start(f);
    if (cap_at_load) model_capture(cap_val);
    if (n_sck == 16) exp_q.push_back(f);
    else             ovf_m = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    if (cap_at_load) begin
      repeat (3) @(negedge clk);
      counter      = 10'h5;
      send_voltage = cap_val;
      @(negedge clk);
      counter      = idle_count();
      repeat (2) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    sck_pulses(n_sck);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, int'(fifo_level), mq.size());
    check({tag, "_ovf"}, int'(overflow), int'(ovf_m));
  endtask

  // monitor: shift in miso on sck rise; a completed 16-bit frame is checked at cs_n rise
  initial begin
    logic [15:0] word;
    int bits;
    logic [15:0] exp;
    word = '0;
    bits = 0;
    forever begin
      @(posedge sck or posedge cs_n);
      if (cs_n === 1'b1) begin
        if (bits == 16) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL frame_unexpected: got %h expected none", word);
          end else begin
            exp = exp_q.pop_front();
            if (word !== exp) begin
              tests_failed++;
              $display("FAIL frame: got %h expected %h", word, exp);
            end
          end
        end
        bits = 0;
      end else begin
        word = {word[14:0], miso};
        bits++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    counter      = 10'h0;
    send_voltage = '0;
    sck          = 1'b0;
    cs_n         = 1'b1;
`ifdef SPI_TX_RAMP_EN
    ramp_sel     = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_miso", int'(miso), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_ovf", int'(overflow), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // empty FIFO -> all-zero frame
    spi_frame(16, 1'b0, '0);
    check_state("empty");

    // single capture
    capture(11'h4A5);
    check_state("one_cap");
    spi_frame(16, 1'b0, '0);
    check_state("one_frame");

    // overflow by nine captures
    reset_dut();
    for (int i = 1; i <= 9; i++) capture(11'(i));
    check_state("nine_cap");
    spi_frame(16, 1'b0, '0);
    spi_frame(16, 1'b0, '0);
    check_state("after_two");

    // full FIFO plus capture coincident with LOAD pop
    capture(11'h03A);
    capture(11'h03B);
    check_state("refill");
    spi_frame(16, 1'b1, 11'h5C3);
    check_state("coincident");

    // abort after 7 sck
    reset_dut();
    capture(11'h111);
    capture(11'h222);
    spi_frame(7, 1'b0, '0);
    check_state("abort");
    spi_frame(16, 1'b0, '0);
    check_state("post_abort");

    // reset in SHIFT while miso carries the valid bit
    reset_dut();
    capture(11'h7FF);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("miso_pre_reset", int'(miso), 1);
    reset = 1'b1;
    model_reset();
    #1;
    check("midreset_miso", int'(miso), 0);
    check("midreset_level", int'(fifo_level), 0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    spi_frame(16, 1'b0, '0);
    check_state("post_reset");

`ifdef SPI_TX_RAMP_EN
    reset_dut();
    ramp_sel = 1'b1;
    for (int i = 0; i < 3; i++) capture(11'($urandom));
    ramp_sel = 1'b0;
    for (int i = 0; i < 3; i++) spi_frame(16, 1'b0, '0);
    check_state("ramp");
`endif

    // randomized mix of captures, frames and aborts
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          int n;
          n = $urandom_range(1, 4);
          for (int k = 0; k < n; k++) capture(11'($urandom));
        end
        2: spi_frame(16, 1'b0, '0);
        default: spi_frame($urandom_range(0, 15), 1'b0, '0);
      endcase
      check_state("rand");
    end

    check("frames_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
